level_meter_mc: RTL and testbench
=================================

# level_meter_mc

Multi-channel, parametrised successor to the single-channel audio LED bar meter. Rectifies offset-binary PCM for `CHANNELS` channels, tracks a per-channel peak with hold and linear decay, latches a clip indicator, and renders one selected channel as an `LED_N`-segment bar or dot display. Sits between the audio sample path (ADC/codec capture) and the board LED/indicator outputs, sequencing channels one per clock after each sample strobe.

## Interface
- `CHANNELS`, 2, number of audio channels (1..8)
- `DATA_W`, 12, sample width; offset binary, mid-scale `2^(DATA_W-1)`
- `LED_N`, 10, LED segments in the bar (1..16)
- `HOLD_SAMPLES`, 4800, sample periods the peak is held before decay starts
- `DECAY_STEP`, 4, magnitude units subtracted per sample period during decay
- `CLIP_LEVEL`, `2^(DATA_W-1)-8`, magnitude at or above which a sample counts as clipped
- `CLIP_HOLD`, 24000, sample periods the clip flag stays asserted after the last clipped sample

Ports:
- `CLK`  in  1  system clock
- `RESET`  in  1  asynchronous, active-high reset
- `SAMPLE_TR`  in  1  single-cycle sample strobe, synchronous to `CLK`
- `VALUE`  in  `CHANNELS*DATA_W`  samples; channel k is bits `[k*DATA_W +: DATA_W]`
- `CH_SEL`  in  `$clog2(CHANNELS)` (min 1)  channel shown on `LED`
- `MODE`  in  1  0 = bar, 1 = dot
- `LED`  out  `LED_N`  segment drive, active-high
- `CLIP`  out  `CHANNELS`  per-channel clip indicator
- `DONE`  out  1  one-cycle pulse when a scan completes and outputs update
- `OVERRUN`  out  1  one-cycle pulse when a `SAMPLE_TR` arrives during a scan

## Operation
- Reset, asynchronous: `LED`, `CLIP`, `DONE` and `OVERRUN` go to 0. All peaks, hold counters and clip counters go to 0. FSM returns to IDLE. A reset during a scan aborts it, and no `DONE` is issued.
- FSM states:
  - IDLE: on `SAMPLE_TR`, capture all of `VALUE` into a sample register, set channel index to 0, go to SCAN.
  - SCAN: process one channel per clock. After channel `CHANNELS-1`, go to UPDATE.
  - UPDATE: register outputs, pulse `DONE`, return to IDLE.
- `SAMPLE_TR` seen in SCAN or UPDATE is dropped and pulses `OVERRUN` on the next cycle. The in-flight scan is unaffected.
- Magnitude per channel, with M = `2^(DATA_W-1)`:
  - v >= M: mag = v - M
  - v < M: mag = M - v, saturated to M-1, so v = 0 gives M-1
  - Range is 0..M-1, width `DATA_W-1`.
- Peak update per channel, once per scan:
  - If mag >= peak: peak <= mag and hold <= `HOLD_SAMPLES`.
  - Else if hold != 0: hold decrements.
  - Else peak <= peak - `DECAY_STEP`, floored at 0; never wraps.
- Clip per channel:
  - mag >= `CLIP_LEVEL` loads clip_cnt with `CLIP_HOLD`.
  - Otherwise clip_cnt decrements toward 0.
  - `CLIP[k]` = (clip_cnt != 0), registered in UPDATE.
- Quantisation: lit = ((peak+1) * `LED_N`) >> (`DATA_W-1`). Range is 0..`LED_N`.
- Rendering, using `CH_SEL` sampled in UPDATE; `CH_SEL` >= `CHANNELS` renders channel 0:
  - Bar mode: LED[i] = (i < lit).
  - Dot mode: only LED[lit-1] is set; all off when lit = 0.
- Peaks and counters advance only on completed scans, never on idle clocks.

## Timing
- `SAMPLE_TR` high at edge t: capture at t, channel k processed at edge t+1+k, UPDATE at edge t+1+`CHANNELS`.
- `LED`, `CLIP` and `DONE` are valid after edge t+1+`CHANNELS`. Latency is `CHANNELS`+1 clocks.
- Minimum strobe spacing without overrun is `CHANNELS`+2 clocks.
- `DONE` and `OVERRUN` are each high for exactly one clock.
- A `SAMPLE_TR` in the same cycle as UPDATE counts as an overrun. A strobe on the cycle after UPDATE (IDLE) is accepted.
- `MODE` and `CH_SEL` changes take effect at the next UPDATE only.

## Test plan
- Defaults, ch0 = 0xFFF, ch1 = 0x800, one strobe → `DONE` at t+3; ch0 mag 2047, lit 10, `CLIP` = 2'b01; `CH_SEL`=0 gives `LED`=10'h3FF, `CH_SEL`=1 gives `LED`=0.
- ch0 = 0x000 → mag 2047, clip set. Then ch0 = 0x400 (mag 1024) → lit 5, bar `LED`=10'h01F, dot `LED`=10'h010.
- `HOLD_SAMPLES`=2, `DECAY_STEP`=512: peak 2047, then zero-level samples → strobes 1–2 hold at 2047, strobes 3–6 give 1535, 1023, 511, 0, and peak stays 0 afterwards.
- `CLIP_HOLD`=3: one clipped sample, then quiet → `CLIP[0]` stays high for 3 more scans, low on the 4th.
- Strobes 2 clocks apart with `CHANNELS`=2 → second strobe pulses `OVERRUN` once, and exactly one `DONE` is issued.
- Assert `RESET` at t+1 of a scan → all outputs 0 immediately, no `DONE`; the next strobe after release completes normally from zero peaks.

Source files
------------

// File: rtl/level_meter_mc_if.sv
// rtl/level_meter_mc_if.sv - sample/render bus for level_meter_mc
// Signals: SAMPLE_TR, VALUE, CH_SEL, MODE (towards meter); LED, CLIP, DONE, OVERRUN (from meter).
// Modports: master = sample source / display consumer, slave = meter.
interface level_meter_mc_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 12,
    parameter int LED_N    = 10
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                       SAMPLE_TR;
    logic [CHANNELS*DATA_W-1:0] VALUE;
    logic [CH_W-1:0]            CH_SEL;
    logic                       MODE;
    logic [LED_N-1:0]           LED;
    logic [CHANNELS-1:0]        CLIP;
    logic                       DONE;
    logic                       OVERRUN;

    modport master (
        output SAMPLE_TR, VALUE, CH_SEL, MODE,
        input  LED, CLIP, DONE, OVERRUN
    );

    modport slave (
        input  SAMPLE_TR, VALUE, CH_SEL, MODE,
        output LED, CLIP, DONE, OVERRUN
    );
endinterface

// File: rtl/level_meter_mc.sv
// rtl/level_meter_mc.sv - multi-channel PCM peak/hold/decay level meter with clip flags and LED bar
// Ports: CLK; RESET (async, active-high); bus (slave modport of level_meter_mc_if):
//   SAMPLE_TR/VALUE/CH_SEL/MODE in, LED/CLIP/DONE/OVERRUN out.
module level_meter_mc #(
    parameter int CHANNELS     = 2,
    parameter int DATA_W       = 12,
    parameter int LED_N        = 10,
    parameter int HOLD_SAMPLES = 4800,
    parameter int DECAY_STEP   = 4,
    parameter int CLIP_LEVEL   = (1 << (DATA_W - 1)) - 8,
    parameter int CLIP_HOLD    = 24000
) (
    input logic             CLK,
    input logic             RESET,
    level_meter_mc_if.slave bus
);
    localparam int MAG_W   = DATA_W - 1;
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int HOLD_W  = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int CLIPC_W = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;
    localparam int LIT_W   = $clog2(LED_N + 1);
    localparam int PROD_W  = MAG_W + 1 + LIT_W;

    localparam logic [DATA_W-1:0]  MID_V     = DATA_W'(1 << MAG_W);
    localparam logic [MAG_W-1:0]   DECAY_V   = MAG_W'(DECAY_STEP);
    localparam logic [MAG_W-1:0]   CLIP_V    = MAG_W'(CLIP_LEVEL);
    localparam logic [HOLD_W-1:0]  HOLD_V    = HOLD_W'(HOLD_SAMPLES);
    localparam logic [CLIPC_W-1:0] CLIPH_V   = CLIPC_W'(CLIP_HOLD);
    localparam logic [CH_W-1:0]    LAST_CH   = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_UPDATE} state_t;

    state_t    state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic      capture, scan_en, update_en, overrun_d;

    logic [CHANNELS*DATA_W-1:0] sample_q;
    logic [MAG_W-1:0]   peak_q  [CHANNELS];
    logic [HOLD_W-1:0]  hold_q  [CHANNELS];
    logic [CLIPC_W-1:0] clipc_q [CHANNELS];
    logic [CHANNELS-1:0] flag_q;
    logic [LED_N-1:0]    led_q, led_d;
    logic [CHANNELS-1:0] clip_q;
    logic                done_q, overrun_q;

    logic [DATA_W-1:0]  samp, neg_diff;
    logic [MAG_W-1:0]   mag, peak_cur, peak_d;
    logic [HOLD_W-1:0]  hold_cur, hold_d;
    logic [CLIPC_W-1:0] clipc_cur, clipc_d;
    logic               flag_d;
    logic [CH_W-1:0]    sel;
    logic [PROD_W-1:0]  prod;
    logic [LIT_W-1:0]   lit;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        capture   = 1'b0;
        scan_en   = 1'b0;
        update_en = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.SAMPLE_TR) begin
                    capture = 1'b1;
                    ch_d    = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                scan_en   = 1'b1;
                overrun_d = bus.SAMPLE_TR;
                if (ch_q == LAST_CH) state_d = S_UPDATE;
                else                 ch_d    = ch_q + 1'b1;
            end
            S_UPDATE: begin
                update_en = 1'b1;
                overrun_d = bus.SAMPLE_TR;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-channel datapath for the channel currently being scanned.
    always_comb begin
        samp     = sample_q[int'(ch_q)*DATA_W +: DATA_W];
        neg_diff = MID_V - samp;
        // Below mid-scale, v = 0 would give exactly M, which saturates to M-1.
        if (samp[DATA_W-1])          mag = samp[MAG_W-1:0];
        else if (neg_diff[DATA_W-1]) mag = '1;
        else                         mag = neg_diff[MAG_W-1:0];

        peak_cur  = peak_q[ch_q];
        hold_cur  = hold_q[ch_q];
        clipc_cur = clipc_q[ch_q];

        peak_d = peak_cur;
        hold_d = hold_cur;
        if (mag >= peak_cur) begin
            peak_d = mag;
            hold_d = HOLD_V;
        end else if (hold_cur != '0) begin
            hold_d = hold_cur - 1'b1;
        end else if (peak_cur >= DECAY_V) begin
            peak_d = peak_cur - DECAY_V;
        end else begin
            peak_d = '0;
        end

        clipc_d = clipc_cur;
        if (mag >= CLIP_V)         clipc_d = CLIPH_V;
        else if (clipc_cur != '0)  clipc_d = clipc_cur - 1'b1;
        // Flag uses the count before this period's decrement so it stays up for
        // CLIP_HOLD full sample periods after the last clipped sample.
        flag_d = (mag >= CLIP_V) || (clipc_cur != '0);
    end

    // Rendering of the selected channel; out-of-range selections fall back to channel 0.
    always_comb begin
        sel  = (int'(bus.CH_SEL) >= CHANNELS) ? '0 : bus.CH_SEL;
        prod = (PROD_W'(peak_q[sel]) + PROD_W'(1)) * PROD_W'(LED_N);
        lit  = LIT_W'(prod >> MAG_W);
        led_d = '0;
        for (int i = 0; i < LED_N; i++) begin
            if (bus.MODE) led_d[i] = (lit != '0) && (i == int'(lit) - 1);
            else          led_d[i] = (i < int'(lit));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sample_q  <= '0;
            flag_q    <= '0;
            led_q     <= '0;
            clip_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                peak_q[k]  <= '0;
                hold_q[k]  <= '0;
                clipc_q[k] <= '0;
            end
        end else begin
            done_q    <= update_en;
            overrun_q <= overrun_d;
            if (capture) sample_q <= bus.VALUE;
            if (scan_en) begin
                peak_q[ch_q]  <= peak_d;
                hold_q[ch_q]  <= hold_d;
                clipc_q[ch_q] <= clipc_d;
                flag_q[ch_q]  <= flag_d;
            end
            if (update_en) begin
                led_q  <= led_d;
                clip_q <= flag_q;
            end
        end
    end

    assign bus.LED     = led_q;
    assign bus.CLIP    = clip_q;
    assign bus.DONE    = done_q;
    assign bus.OVERRUN = overrun_q;
endmodule

// File: tb/tb_level_meter_mc.sv
// tb/tb_level_meter_mc.sv - directed self-checking bench for level_meter_mc (default DUT and fast hold/decay/clip DUT)
module tb_level_meter_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    level_meter_mc_if #(.CHANNELS(2), .DATA_W(12), .LED_N(10)) ifa ();
    level_meter_mc_if #(.CHANNELS(2), .DATA_W(12), .LED_N(10)) ifb ();

    level_meter_mc #(.CHANNELS(2), .DATA_W(12), .LED_N(10)) dut_a (
        .CLK(clk), .RESET(rst), .bus(ifa)
    );

    level_meter_mc #(.CHANNELS(2), .DATA_W(12), .LED_N(10),
                     .HOLD_SAMPLES(2), .DECAY_STEP(512), .CLIP_HOLD(3)) dut_b (
        .CLK(clk), .RESET(rst), .bus(ifb)
    );

    logic [11:0] bnd_v    [4] = '{12'hFF8, 12'hFF7, 12'h8CC, 12'h8CB};
    logic [9:0]  bnd_led  [4] = '{10'h1FF, 10'h1FF, 10'h001, 10'h000};
    logic [1:0]  bnd_clip [4] = '{2'b01, 2'b00, 2'b00, 2'b00};

    logic [9:0]  dec_led  [7] = '{10'h3FF, 10'h3FF, 10'h07F, 10'h01F, 10'h003, 10'h000, 10'h000};
    logic [1:0]  dec_clip [7] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    int gap_v  [3] = '{2, 3, 4};
    int gap_dn [3] = '{1, 1, 2};
    int gap_ov [3] = '{1, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_tr(input logic v);
        ifa.SAMPLE_TR = v;
        ifb.SAMPLE_TR = v;
    endtask

    task automatic set_view(input logic sel, input logic mode);
        ifa.CH_SEL = sel;
        ifb.CH_SEL = sel;
        ifa.MODE   = mode;
        ifb.MODE   = mode;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One strobe, bounded wait for DONE, latency and pulse-width checks; returns at a quiet negedge.
    task automatic scan(input logic [23:0] v);
        int lat;
        @(negedge clk);
        ifa.VALUE = v;
        ifb.VALUE = v;
        set_tr(1'b1);
        @(negedge clk);
        set_tr(1'b0);
        lat = 0;
        while (!ifa.DONE && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", lat, 3);
        check("done_b_aligned", ifb.DONE, 1);
        @(negedge clk);
        check("done_one_clk", ifa.DONE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dn;
        int ov;
        set_tr(1'b0);
        ifa.VALUE = 24'h800800;
        ifb.VALUE = 24'h800800;
        set_view(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_led", ifa.LED, 0);
        check("rst_clip", ifa.CLIP, 0);
        check("rst_done", ifa.DONE, 0);
        check("rst_ovr", ifa.OVERRUN, 0);
        check("rst_led_b", ifb.LED, 0);
        rst = 1'b0;

        // Full-scale positive on ch0, mid-scale on ch1.
        scan(24'h800FFF);
        check("t1_led_ch0", ifa.LED, 10'h3FF);
        check("t1_clip", ifa.CLIP, 2'b01);
        check("t1_led_b", ifb.LED, 10'h3FF);
        check("t1_ovr", ifa.OVERRUN, 0);
        set_view(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("t1_sel_deferred", ifa.LED, 10'h3FF);
        scan(24'h800FFF);
        check("t1_led_ch1", ifa.LED, 10'h000);
        set_view(1'b0, 1'b0);

        // Zero code saturates to full magnitude.
        do_reset();
        scan(24'h800000);
        check("t2_led_zero", ifa.LED, 10'h3FF);
        check("t2_clip_zero", ifa.CLIP, 2'b01);

        // Half magnitude: bar then dot.
        do_reset();
        scan(24'h800400);
        check("t2_bar", ifa.LED, 10'h01F);
        check("t2_clip_half", ifa.CLIP, 2'b00);
        set_view(1'b0, 1'b1);
        scan(24'h800400);
        check("t2_dot", ifa.LED, 10'h010);
        check("t2_dot_b", ifb.LED, 10'h010);
        set_view(1'b0, 1'b0);

        // Clip level and first-segment boundaries, each from fresh peaks.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            scan({12'h800, bnd_v[i]});
            check("bnd_led", ifa.LED, bnd_led[i]);
            check("bnd_clip", ifa.CLIP, bnd_clip[i]);
        end

        // Hold/decay and clip hold on the fast DUT; default DUT keeps holding.
        do_reset();
        scan(24'h800FFF);
        check("dec_start_led", ifb.LED, 10'h3FF);
        check("dec_start_clip", ifb.CLIP, 2'b01);
        for (int i = 0; i < 7; i++) begin
            scan(24'h800800);
            check("dec_led_b", ifb.LED, dec_led[i]);
            check("dec_clip_b", ifb.CLIP, dec_clip[i]);
            check("dec_led_a", ifa.LED, 10'h3FF);
            check("dec_clip_a", ifa.CLIP, 2'b01);
        end

        // Strobe spacing: overrun during SCAN and UPDATE, accepted from IDLE.
        for (int g = 0; g < 3; g++) begin
            dn = 0;
            ov = 0;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                dn += int'(ifa.DONE);
                ov += int'(ifa.OVERRUN);
                set_tr(c == 0 || c == gap_v[g]);
            end
            set_tr(1'b0);
            check("gap_done_count", dn, gap_dn[g]);
            check("gap_ovr_count", ov, gap_ov[g]);
        end

        // Reset in the middle of a scan.
        scan(24'h800FFF);
        check("pre_rst_led", ifa.LED, 10'h3FF);
        @(negedge clk);
        set_tr(1'b1);
        @(negedge clk);
        set_tr(1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_led", ifa.LED, 0);
        check("mid_rst_clip", ifa.CLIP, 0);
        check("mid_rst_done", ifa.DONE, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            dn += int'(ifa.DONE);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            dn += int'(ifa.DONE);
        end
        check("mid_rst_no_done", dn, 0);
        scan(24'h8008CC);
        check("post_rst_led", ifa.LED, 10'h001);
        check("post_rst_clip", ifa.CLIP, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
